// File: rtl/mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_sequencer_pkg
// Shared types for the EX-stage multiply sequencer: M-extension funct3 codes,
// sequencer states, operand signedness classes, the request payload and the
// operand-cache entry. Also a helper mapping funct3 to its signedness class.
// -----------------------------------------------------------------------------
package mul_sequencer_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3W  = 3;

    // M-extension multiply funct3 codes (funct3[2] set means divide/rem,
    // which this sequencer treats as illegal)
    typedef enum logic [F3W-1:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011
    } m_funct3_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } mul_seq_state_t;

    // Operand signedness: signed*signed, signed*unsigned, unsigned*unsigned
    typedef enum logic [1:0] {
        SS = 2'd0,
        SU = 2'd1,
        UU = 2'd2
    } mul_class_t;

    // Request payload carried alongside req_valid/req_ready
    typedef struct packed {
        logic [F3W-1:0]  funct3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mul_req_t;

    // One operand-cache entry; mul and mulh share a class, so a cached
    // SS product serves either half
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        mul_class_t      cls;
    } mul_cache_entry_t;

    function automatic logic funct3_illegal(input logic [F3W-1:0] f);
        return f[2];
    endfunction

    function automatic mul_class_t funct3_class(input logic [F3W-1:0] f);
        mul_class_t c;
        case (f)
            mul, mulh: c = SS;
            mulhsu:    c = SU;
            mulhu:     c = UU;
            default:   c = SS;
        endcase
        return c;
    endfunction

endpackage : mul_sequencer_pkg

// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if
// Request/response handshake bundle between the issuing pipeline (master) and
// the multiply sequencer (slave).
//   req_valid   master->slave  request present
//   req_ready   slave->master  request accepted when valid && ready
//   req_payload master->slave  funct3, rs1, rs2
//   resp_valid  slave->master  result available
//   resp_ready  master->slave  consumer takes result when valid && ready
//   resp_data   slave->master  32-bit result
// -----------------------------------------------------------------------------
interface mul_sequencer_if;
    import mul_sequencer_pkg::*;

    logic                req_valid;
    logic                req_ready;
    mul_req_t            req_payload;
    logic                resp_valid;
    logic                resp_ready;
    logic [XLEN-1:0]     resp_data;

    modport master (
        output req_valid,
        output req_payload,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_payload,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface : mul_sequencer_if

// File: rtl/mul_operand_cache.sv
// -----------------------------------------------------------------------------
// mul_operand_cache
// One-entry cache of the operand pair and class of the last completed
// multiplier run, so a mul/mulh pair on identical operands can reuse the
// product already sitting in the multiplier's stage-2 registers.
//   gclk, rst        clock, synchronous active-high reset (entry invalid)
//   i_set            capture i_set_a/b/class and mark valid
//   i_invalidate     clear valid (wins over i_set)
//   i_set_a/b/class  entry contents to capture
//   i_cmp_a/b/class  lookup key
//   o_hit_c          combinational: valid and key matches entry
// -----------------------------------------------------------------------------
module mul_operand_cache
    import mul_sequencer_pkg::*;
(
    input  logic             gclk,
    input  logic             rst,
    input  logic             i_set,
    input  logic             i_invalidate,
    input  logic [XLEN-1:0]  i_set_a,
    input  logic [XLEN-1:0]  i_set_b,
    input  mul_class_t       i_set_class,
    input  logic [XLEN-1:0]  i_cmp_a,
    input  logic [XLEN-1:0]  i_cmp_b,
    input  mul_class_t       i_cmp_class,
    output logic             o_hit_c
);

    logic             r_valid;
    mul_cache_entry_t r_entry;

    // Valid bit: invalidate takes priority over set
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_invalidate) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end
    end

    // Entry payload, only rewritten on set
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_entry <= '0;
        end else if (i_set && !i_invalidate) begin
            r_entry.a   <= i_set_a;
            r_entry.b   <= i_set_b;
            r_entry.cls <= i_set_class;
        end
    end

    assign o_hit_c = r_valid
                  && (r_entry.a   == i_cmp_a)
                  && (r_entry.b   == i_cmp_b)
                  && (r_entry.cls == i_cmp_class);

endmodule : mul_operand_cache

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Sequences the two-stage Booth/Wallace multiplier in EX: accepts one multiply
// request, latches operands/funct3, pulses stage-1 load then stage-2 load, and
// returns the result. A one-entry operand cache short-circuits a repeat of the
// same operand pair and class. Flush aborts in-flight work.
//   gclk, rst        clock, synchronous active-high reset
//   i_flush          pipeline flush
//   bus              request/response handshake (slave side)
//   o_mul_a/b        latched operands to the multiplier
//   o_mul_funct3     latched funct3 to the multiplier
//   o_mul_enable     stage-1 (partial product) load, one cycle in ISSUE
//   o_mul_add        stage-2 (compressor) load, one cycle in ACCUM
//   i_mul_f          multiplier result, combinational from stage-2 registers
//   o_busy           sequencer not idle
// -----------------------------------------------------------------------------
module mul_sequencer
    import mul_sequencer_pkg::*;
(
    input  logic               gclk,
    input  logic               rst,
    input  logic               i_flush,
    mul_sequencer_if.slave     bus,
    output logic [XLEN-1:0]    o_mul_a,
    output logic [XLEN-1:0]    o_mul_b,
    output logic [F3W-1:0]     o_mul_funct3,
    output logic               o_mul_enable,
    output logic               o_mul_add,
    input  logic [XLEN-1:0]    i_mul_f,
    output logic               o_busy
);

    mul_seq_state_t r_state;
    mul_seq_state_t w_state_next;

    mul_req_t       r_req;
    logic           r_illegal;
    logic           r_mul_enable;
    logic           r_mul_add;
    logic           r_resp_valid;
    logic           r_busy;

    logic           w_accept;
    logic           w_req_illegal;
    mul_class_t     w_req_class;
    mul_class_t     w_lat_class;
    logic           w_hit;
    logic           w_cache_set;
    logic           w_cache_inval;

    // Flush blocks acceptance so a squashed instruction never enters
    assign bus.req_ready = (r_state == IDLE) && !i_flush;
    assign w_accept      = bus.req_valid && bus.req_ready;

    assign w_req_illegal = funct3_illegal(bus.req_payload.funct3);
    assign w_req_class   = funct3_class(bus.req_payload.funct3);
    assign w_lat_class   = funct3_class(r_req.funct3);

    // Lookup uses the incoming request; fill uses the latched operands
    mul_operand_cache u_cache (
        .gclk         (gclk),
        .rst          (rst),
        .i_set        (w_cache_set),
        .i_invalidate (w_cache_inval),
        .i_set_a      (r_req.a),
        .i_set_b      (r_req.b),
        .i_set_class  (w_lat_class),
        .i_cmp_a      (bus.req_payload.a),
        .i_cmp_b      (bus.req_payload.b),
        .i_cmp_class  (w_req_class),
        .o_hit_c      (w_hit)
    );

    // State register
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and cache control
    always_comb begin
        w_state_next  = r_state;
        w_cache_set   = 1'b0;
        w_cache_inval = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_illegal) begin
                        w_state_next = DONE;
                    end else if (w_hit) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next  = ISSUE;
                        w_cache_inval = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (i_flush) begin
                    w_state_next  = IDLE;
                    w_cache_inval = 1'b1;
                end else begin
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                // Stage-2 loads this cycle, so the product matches the
                // latched operands from the next cycle on
                if (i_flush) begin
                    w_state_next  = IDLE;
                    w_cache_inval = 1'b1;
                end else begin
                    w_state_next = DONE;
                    w_cache_set  = 1'b1;
                end
            end
            DONE: begin
                // Flush drops the response but the stage-2 product is still
                // valid, so the cache entry is kept
                if (i_flush || bus.resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered state-decoded outputs, computed from the next state
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_mul_enable <= 1'b0;
            r_mul_add    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mul_enable <= (w_state_next == ISSUE);
            r_mul_add    <= (w_state_next == ACCUM);
            r_resp_valid <= (w_state_next == DONE);
            r_busy       <= (w_state_next != IDLE);
        end
    end

    // Operand/funct3 latch, held until the next accept
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_req     <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_req     <= bus.req_payload;
            r_illegal <= w_req_illegal;
        end
    end

    assign o_mul_a      = r_req.a;
    assign o_mul_b      = r_req.b;
    assign o_mul_funct3 = r_req.funct3;
    assign o_mul_enable = r_mul_enable;
    assign o_mul_add    = r_mul_add;
    assign o_busy       = r_busy;

    // Result passes straight from the stage-2 output; illegal ops return 0
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = (r_resp_valid && !r_illegal) ? i_mul_f : '0;

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Self-checking bench: a directed table, hand-written flush/reset sequences and
// randomized traffic, checked against an arithmetic reference with a one-entry
// operand-cache model. A behavioural two-stage multiplier stands in for the
// datapath.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    logic        gclk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [2:0]  mul_funct3;
    logic        mul_enable;
    logic        mul_add;
    logic [31:0] mul_f;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    mul_sequencer_if bus ();

    mul_sequencer u_dut (
        .gclk         (gclk),
        .rst          (rst),
        .i_flush      (flush),
        .bus          (bus),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .o_mul_funct3 (mul_funct3),
        .o_mul_enable (mul_enable),
        .o_mul_add    (mul_add),
        .i_mul_f      (mul_f),
        .o_busy       (busy)
    );

    always #5 gclk = ~gclk;

    // Exact 64-bit product for the operand signedness implied by funct3
    function automatic logic [63:0] full_prod(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f3);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3[1:0])
            2'b10:   return 64'(sa * longint'(ub));
            2'b11:   return ua * ub;
            default: return 64'(sa * sb);
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3);
        logic [63:0] p;
        if (f3[2]) return 32'h0;
        p = full_prod(a, b, f3);
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic int class_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b10) return 1;
        if (f3[1:0] == 2'b11) return 2;
        return 0;
    endfunction

    // Behavioural multiplier: stage 1 captures operands, stage 2 the product;
    // the output half is selected live by the current funct3
    logic [31:0] s1_a  = '0;
    logic [31:0] s1_b  = '0;
    logic [2:0]  s1_f3 = '0;
    logic [63:0] s2_p  = '0;
    always @(posedge gclk) begin
        if (mul_enable) begin
            s1_a  <= mul_a;
            s1_b  <= mul_b;
            s1_f3 <= mul_funct3;
        end
        if (mul_add) s2_p <= full_prod(s1_a, s1_b, s1_f3);
    end
    assign mul_f = (mul_funct3 == 3'b000) ? s2_p[31:0] : s2_p[63:32];

    // Reference operand-cache state
    logic        m_valid;
    logic [31:0] m_a, m_b;
    int          m_cls;

    task automatic model_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                             output logic [31:0] d, output int lat);
        d = ref_mul(a, b, f3);
        if (f3[2]) begin
            lat = 1;
        end else if (m_valid && m_a == a && m_b == b && m_cls == class_of(f3)) begin
            lat = 1;
        end else begin
            lat     = 3;
            m_valid = 1'b1;
            m_a     = a;
            m_b     = b;
            m_cls   = class_of(f3);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, " req_ready"},  64'(bus.req_ready),  64'd1);
        check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, " resp_data"},  64'(bus.resp_data),  64'd0);
        check({tag, " busy"},       64'(busy),           64'd0);
        check({tag, " mul_enable"}, 64'(mul_enable),     64'd0);
        check({tag, " mul_add"},    64'(mul_add),        64'd0);
        check({tag, " mul_a"},      64'(mul_a),          64'd0);
        check({tag, " mul_b"},      64'(mul_b),          64'd0);
        check({tag, " mul_funct3"}, 64'(mul_funct3),     64'd0);
    endtask

    // Present a request and let it be accepted; returns at posedge+1 of T+1
    task automatic issue_only(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        bus.req_valid          = 1'b1;
        bus.req_payload.a      = a;
        bus.req_payload.b      = b;
        bus.req_payload.funct3 = f3;
        @(negedge gclk);
        check("idle req_ready",  64'(bus.req_ready),  64'd1);
        check("idle resp_valid", 64'(bus.resp_valid), 64'd0);
        check("idle busy",       64'(busy),           64'd0);
        @(posedge gclk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Full transaction from IDLE (called at posedge+1) through the response
    // handshake; returns at posedge+1 of the cycle after the handshake
    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          input int hold, input logic [31:0] exp_data, input int exp_lat);
        int lat;
        issue_only(a, b, f3);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge gclk);
            if (k == 1) begin
                check("mul_a latched",      64'(mul_a),      64'(a));
                check("mul_b latched",      64'(mul_b),      64'(b));
                check("mul_funct3 latched", 64'(mul_funct3), 64'(f3));
            end
            check("mul_enable", 64'(mul_enable), 64'(exp_lat == 3 && k == 1));
            check("mul_add",    64'(mul_add),    64'(exp_lat == 3 && k == 2));
            if (bus.resp_valid) lat = k;
            else begin @(posedge gclk); #1; end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        if (lat == 0) begin
            rst = 1'b1;
            @(posedge gclk); #1;
            rst = 1'b0;
            m_valid = 1'b0;
            return;
        end
        check("resp_data", 64'(bus.resp_data), 64'(exp_data));
        for (int h = 0; h < hold; h++) begin
            @(posedge gclk); #1;
            @(negedge gclk);
            check("hold resp_valid", 64'(bus.resp_valid), 64'd1);
            check("hold resp_data",  64'(bus.resp_data),  64'(exp_data));
            check("hold req_ready",  64'(bus.req_ready),  64'd0);
            check("hold busy",       64'(busy),           64'd1);
        end
        bus.resp_ready = 1'b1;
        @(posedge gclk); #1;
        bus.resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        int          hold;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] d;
        int          l;
        logic [31:0] ra, rb, pool[5];
        logic [2:0]  rf;

        vecs[0]  = '{32'd7,         32'hFFFF_FFFD, 3'b000, 0, 32'hFFFF_FFEB, 3};
        vecs[1]  = '{32'h8000_0000, 32'h8000_0000, 3'b001, 0, 32'h4000_0000, 3};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 3'b000, 0, 32'h0000_0000, 1};
        vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 0, 32'hFFFF_FFFE, 3};
        vecs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 4, 32'hFFFF_FFFF, 3};
        vecs[5]  = '{32'd5,         32'd6,         3'b100, 1, 32'h0000_0000, 1};
        vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 0, 32'hFFFF_FFFF, 1};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 0, 32'h0000_0000, 3};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 0, 32'h0000_0001, 1};
        vecs[9]  = '{32'h0001_0000, 32'h0001_0000, 3'b000, 0, 32'h0000_0000, 3};
        vecs[10] = '{32'h0001_0000, 32'h0001_0000, 3'b001, 2, 32'h0000_0001, 1};
        vecs[11] = '{32'h0001_0000, 32'h0001_0000, 3'b011, 0, 32'h0000_0001, 3};
        vecs[12] = '{32'd2,         32'd3,         3'b010, 0, 32'h0000_0000, 3};
        vecs[13] = '{32'd0,         32'd0,         3'b111, 0, 32'h0000_0000, 1};

        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_payload = '0;
        bus.resp_ready = 1'b0;
        m_valid = 1'b0;
        m_a = '0;
        m_b = '0;
        m_cls = 0;
        repeat (3) @(posedge gclk);
        #1 rst = 1'b0;
        @(negedge gclk);
        reset_check("reset");
        @(posedge gclk); #1;

        // Directed table; the cache model is kept in step for later phases
        foreach (vecs[i]) begin
            model_txn(vecs[i].a, vecs[i].b, vecs[i].f3, d, l);
            do_txn(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].hold,
                   vecs[i].exp_data, vecs[i].exp_lat);
        end

        // Flush in ACCUM: abort, no response, cache invalidated
        issue_only(32'd3, 32'd5, 3'b011);
        @(negedge gclk);
        check("flushA mul_enable", 64'(mul_enable), 64'd1);
        @(posedge gclk); #1;
        flush = 1'b1;
        @(negedge gclk);
        check("flushA in ACCUM busy", 64'(busy), 64'd1);
        @(posedge gclk); #1;
        flush = 1'b0;
        @(negedge gclk);
        check("flushA busy",       64'(busy),           64'd0);
        check("flushA resp_valid", 64'(bus.resp_valid), 64'd0);
        check("flushA req_ready",  64'(bus.req_ready),  64'd1);
        @(posedge gclk); #1;
        @(negedge gclk);
        check("flushA later resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge gclk); #1;
        m_valid = 1'b0;
        model_txn(32'd3, 32'd5, 3'b011, d, l);
        do_txn(32'd3, 32'd5, 3'b011, 0, d, l);

        // Flush in DONE: response dropped, cache kept
        model_txn(32'd9, 32'd11, 3'b000, d, l);
        issue_only(32'd9, 32'd11, 3'b000);
        @(posedge gclk); #1;
        @(posedge gclk); #1;
        @(negedge gclk);
        check("flushD resp_valid", 64'(bus.resp_valid), 64'd1);
        check("flushD resp_data",  64'(bus.resp_data),  64'd99);
        @(posedge gclk); #1;
        flush = 1'b1;
        @(negedge gclk);
        check("flushD still valid", 64'(bus.resp_valid), 64'd1);
        @(posedge gclk); #1;
        flush = 1'b0;
        @(negedge gclk);
        check("flushD dropped resp_valid", 64'(bus.resp_valid), 64'd0);
        check("flushD busy",               64'(busy),           64'd0);
        @(posedge gclk); #1;
        model_txn(32'd9, 32'd11, 3'b000, d, l);
        do_txn(32'd9, 32'd11, 3'b000, 0, d, l);

        // Flush in IDLE beats a simultaneous request
        bus.req_valid          = 1'b1;
        bus.req_payload.a      = 32'd4;
        bus.req_payload.b      = 32'd4;
        bus.req_payload.funct3 = 3'b000;
        flush = 1'b1;
        @(negedge gclk);
        check("flushI req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge gclk); #1;
        bus.req_valid = 1'b0;
        flush = 1'b0;
        @(negedge gclk);
        check("flushI busy",       64'(busy),           64'd0);
        check("flushI mul_enable", 64'(mul_enable),     64'd0);
        check("flushI mul_a kept", 64'(mul_a),          64'd9);
        check("flushI resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge gclk); #1;

        // Reset during ISSUE
        issue_only(32'h1234_5678, 32'h0000_0010, 3'b001);
        @(negedge gclk);
        check("rstI mul_enable", 64'(mul_enable), 64'd1);
        rst = 1'b1;
        @(posedge gclk); #1;
        rst = 1'b0;
        @(negedge gclk);
        reset_check("rst in ISSUE");
        @(posedge gclk); #1;
        m_valid = 1'b0;

        // Randomized traffic with operand reuse to exercise the cache
        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;
        ra = 32'h0;
        rb = 32'h0;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) >= 4 || t == 0) begin
                ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
                rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            end
            rf = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                             : 3'($urandom_range(0, 3));
            model_txn(ra, rb, rf, d, l);
            do_txn(ra, rb, rf, $urandom_range(0, 2), d, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mul_sequencer
